// File: rtl/interpolate_upsample.sv
`default_nettype none
// ============================================================================
//  Module      : interpolate_upsample
//  Description : Upsamples a decimated signed sample stream to full clock rate.
//                Each new sample starts an interpolation span of
//                N = 2^LOG2_DECIMATION_FACTOR cycles. The span is either a
//                linear ramp from the current output level to the new sample
//                (linear_i = 1) or a zero-order hold (linear_i = 0). The
//                accumulator is scaled, floor-shifted and saturated into
//                data_o.
//  Ports       : clk_i         - clock, rising edge
//                rst_i         - asynchronous active-high reset
//                data_valid_i  - one-cycle strobe qualifying data_i
//                data_i        - signed decimated input sample
//                linear_i      - 1 = linear interpolation, 0 = zero-order hold
//                clear_flags_i - synchronous clear of the sticky flags
//                data_o        - registered signed full-rate output
//                underrun_o    - sticky: span ended with no new sample
//                overrun_o     - sticky: new sample arrived mid-span
//  Revision    : 1.0 - initial release
// ============================================================================
module interpolate_upsample #(
   parameter int INPUT_WIDTH            = 18,
   parameter int OUTPUT_WIDTH           = 14,
   parameter int LOG2_DECIMATION_FACTOR = 5,
   parameter int SHIFT                  = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           data_valid_i,
   input  logic signed [INPUT_WIDTH-1:0]  data_i,
   input  logic                           linear_i,
   input  logic                           clear_flags_i,
   output logic signed [OUTPUT_WIDTH-1:0] data_o,
   output logic                           underrun_o,
   output logic                           overrun_o
);

   localparam int L  = LOG2_DECIMATION_FACTOR;
   localparam int AW = INPUT_WIDTH + L;   // accumulator width
   localparam int DW = INPUT_WIDTH + 1;   // per-cycle delta width
   localparam int PW = L + 1;             // phase counter width (counts 0..N)

   localparam logic [PW-1:0] C_SPAN = {1'b1, {L{1'b0}}};

   // Saturation bounds expressed at accumulator width so comparisons stay signed.
   localparam logic signed [AW-1:0] C_SAT_MAX =
      {{(AW-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
   localparam logic signed [AW-1:0] C_SAT_MIN =
      {{(AW-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t                          state_q,    state_d;
   logic signed [AW-1:0]            acc_q,      acc_d;
   logic signed [DW-1:0]            delta_q,    delta_d;
   logic        [PW-1:0]            phase_q,    phase_d;
   logic signed [OUTPUT_WIDTH-1:0]  data_q,     data_d;
   logic                            underrun_q, underrun_d;
   logic                            overrun_q,  overrun_d;

   logic signed [AW-1:0]            w_sample_acc;
   logic signed [INPUT_WIDTH-1:0]   w_acc_int;
   logic signed [DW-1:0]            w_new_delta;
   logic signed [AW-1:0]            w_shifted;
   logic                            w_span_done;
   logic                            w_load;
   logic                            w_set_underrun;
   logic                            w_set_overrun;

   // New sample scaled to accumulator units.
   assign w_sample_acc = {data_i, {L{1'b0}}};
   // Integer part of the accumulator (acc >>> L); the ramp starts from here,
   // so a mid-span reload continues from the current output level.
   assign w_acc_int    = acc_q[AW-1:L];
   assign w_new_delta  = {data_i[INPUT_WIDTH-1], data_i}
                       - {w_acc_int[INPUT_WIDTH-1], w_acc_int};
   assign w_span_done  = (phase_q == C_SPAN);
   assign w_shifted    = acc_q >>> (L + SHIFT);

   always_comb begin
      state_d        = state_q;
      acc_d          = acc_q;
      delta_d        = delta_q;
      phase_d        = phase_q;
      w_load         = 1'b0;
      w_set_underrun = 1'b0;
      w_set_overrun  = 1'b0;

      case (state_q)
         IDLE: begin
            acc_d = '0;
            if (data_valid_i) begin
               acc_d   = w_sample_acc;
               delta_d = '0;
               phase_d = '0;
               state_d = PRIME;
            end
         end
         PRIME: begin
            if (data_valid_i) begin
               w_load  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            // A fresh sample always wins over accumulation.
            if (data_valid_i) begin
               w_load        = 1'b1;
               w_set_overrun = ~w_span_done;
            end else if (!w_span_done) begin
               acc_d   = acc_q + AW'(delta_q);
               phase_d = phase_q + PW'(1);
            end else begin
               w_set_underrun = 1'b1;
               state_d        = HOLD;
            end
         end
         HOLD: begin
            if (data_valid_i) begin
               w_load  = 1'b1;
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase

      // linear_i only matters here, so mid-span changes wait for the next load.
      if (w_load) begin
         phase_d = '0;
         if (linear_i) begin
            delta_d = w_new_delta;
         end else begin
            acc_d   = w_sample_acc;
            delta_d = '0;
         end
      end
   end

   // Output stage: floor shift then clamp to the signed output range.
   always_comb begin
      data_d = w_shifted[OUTPUT_WIDTH-1:0];
      if (w_shifted > C_SAT_MAX) begin
         data_d = C_SAT_MAX[OUTPUT_WIDTH-1:0];
      end else if (w_shifted < C_SAT_MIN) begin
         data_d = C_SAT_MIN[OUTPUT_WIDTH-1:0];
      end
   end

   // Sticky flags: a set event in the same cycle overrides the clear.
   always_comb begin
      underrun_d = (underrun_q & ~clear_flags_i) | w_set_underrun;
      overrun_d  = (overrun_q  & ~clear_flags_i) | w_set_overrun;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         delta_q    <= '0;
         phase_q    <= '0;
         data_q     <= '0;
         underrun_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         delta_q    <= delta_d;
         phase_q    <= phase_d;
         data_q     <= data_d;
         underrun_q <= underrun_d;
         overrun_q  <= overrun_d;
      end
   end

   assign data_o     = data_q;
   assign underrun_o = underrun_q;
   assign overrun_o  = overrun_q;

endmodule
`default_nettype wire

// File: doc/interpolate_upsample.md
INTERPOLATE_UPSAMPLE -- requirements
Module: interpolate_upsample

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 18: width of signed decimated input sample.
REQ-002 SHALL have parameter OUTPUT_WIDTH, default 14: width of signed full-rate output.
REQ-003 SHALL have parameter LOG2_DECIMATION_FACTOR, default 5: L; interpolation span N = 2^L cycles.
REQ-004 SHALL have parameter SHIFT, default 4: arithmetic right shift applied after interpolation, before saturation.
REQ-005 SHALL have port clk_i, input, 1: single clock; all logic on rising edge.
REQ-006 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port data_valid_i, input, 1: one-cycle strobe qualifying data_i.
REQ-008 SHALL have port data_i, input, INPUT_WIDTH: signed two's-complement decimated sample.
REQ-009 SHALL have port linear_i, input, 1: 1 = linear interpolation, 0 = zero-order hold.
REQ-010 SHALL have port clear_flags_i, input, 1: synchronous clear of sticky flags.
REQ-011 SHALL have port data_o, output, OUTPUT_WIDTH: registered signed full-rate output.
REQ-012 SHALL have port underrun_o, output, 1: sticky; interpolation span ended without a new sample.
REQ-013 SHALL have port overrun_o, output, 1: sticky; new sample arrived before span ended.

Function
REQ-014 SHALL keep an accumulator acc, signed INPUT_WIDTH+L bits, a signed delta of INPUT_WIDTH+1 bits and a phase counter of L+1 bits.
REQ-015 SHALL drive data_o, one cycle after acc, as saturate(acc >>> (L+SHIFT)) to OUTPUT_WIDTH; floor rounding; clamp to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1].
REQ-016 SHALL implement states IDLE, PRIME, RUN, HOLD.
REQ-017 IDLE: acc = 0; on data_valid_i -> acc <= data_i<<L, phase <= 0, go PRIME.
REQ-018 PRIME: hold acc; on data_valid_i -> load sample per REQ-019, go RUN.
REQ-019 Sample load (PRIME/RUN/HOLD): linear_i=1 -> delta <= data_i - (acc>>>L), acc unchanged, phase <= 0; linear_i=0 -> acc <= data_i<<L, delta <= 0, phase <= 0.
REQ-020 RUN: each cycle without data_valid_i, phase < N -> acc <= acc + delta, phase++; acc reaches data_i<<L exactly after N cycles.
REQ-021 RUN, phase = N, no data_valid_i -> go HOLD, set underrun_o; acc held.
REQ-022 RUN, data_valid_i with phase = N -> normal reload, no flag; phase < N -> reload from current acc (no output jump), set overrun_o.
REQ-023 HOLD: acc constant; data_valid_i -> reload per REQ-019, go RUN.
REQ-024 data_valid_i SHALL take priority over accumulate in the same cycle.
REQ-025 clear_flags_i SHALL clear both flags; simultaneous set event wins (flag stays 1).
REQ-026 Latency: sample strobed at edge k affects data_o from edge k+1 (ZOH: data_o = sat(data_i>>>SHIFT) at k+1).
REQ-027 linear_i SHALL be sampled only at sample load; mid-span changes take effect at next load.

Reset
REQ-028 rst_i high SHALL immediately force state IDLE, acc, delta, phase, data_o, underrun_o, overrun_o to 0, regardless of clock.
REQ-029 After rst_i deasserts, first data_valid_i SHALL be treated as IDLE entry (REQ-017).

Verification (N=32, INPUT_WIDTH=18, OUTPUT_WIDTH=14, SHIFT=4 unless stated)
REQ-030 Reset: assert rst_i mid-RUN between edges -> data_o, flags = 0 without a clock edge; state IDLE.
REQ-031 Prime: data_i=320 strobe from IDLE -> data_o = 20 one cycle later, held constant.
REQ-032 Linear ramp: strobes every 32 cycles, 320 then 960, linear_i=1 -> data_o = floor((10240+640p)/512), p=1..32, ending at 60; no flags.
REQ-033 ZOH: same stimulus, linear_i=0 -> data_o steps 20 -> 60 one cycle after second strobe.
REQ-034 Underrun/overrun: omit strobe after 32 cycles -> HOLD, underrun_o=1, data_o constant; strobe 10 cycles after a load -> overrun_o=1, no data_o discontinuity; clear_flags_i -> both 0.
REQ-035 Saturation (SHIFT=2): data_i=131071 ZOH -> data_o=8191; data_i=-131072 -> data_o=-8192.
